sram_controller: RTL and testbench

- Sits directly downstream of the 2-way cache controller and drives the board's external asynchronous 256K x 16 SRAM.
- Serves the cache's 32-bit word read/write requests using the sram_read/sram_write/sram_ready handshake.
- Splits each word into two 16-bit SRAM accesses, low halfword first, with a programmable number of wait cycles per half.

---
 rtl/sram_controller_if.sv | 19 +
 rtl/sram_controller.sv | 126 ++++++++++++
 tb/tb_sram_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Cache-side word request bus between the cache controller and the SRAM controller.
interface sram_controller_if;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  modport master (
    output sram_read, sram_write, sram_address, sram_wdata,
    input  sram_rdata, sram_ready
  );

  modport slave (
    input  sram_read, sram_write, sram_address, sram_wdata,
    output sram_rdata, sram_ready
  );
endinterface

// File: rtl/sram_controller.sv
// Word-to-halfword bridge from the cache request bus to a 256K x 16 asynchronous SRAM.
// Each 32-bit access is split into two halfword accesses, low half first,
// and each half lasts WAIT_CYCLES+1 clock cycles.
//
// state  | meaning
// IDLE   | waiting for a request; strobes inactive, SRAM_ADDR parked at 0
// ACCESS | one halfword access in progress (half_q selects which half)
// DONE   | one-cycle sram_ready pulse; request inputs are ignored here
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  output logic [17:0]        SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [31:0] BASE_C = 32'(BASE_ADDR);
  localparam logic [3:0]  WAIT_C = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic        half_q, half_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [17:0] addr_q, addr_d;

  logic [31:0] offset;
  logic        last;
  logic        unused_offset;

  assign offset        = bus.sram_address - BASE_C;
  assign last          = (cnt_q == WAIT_C);
  assign unused_offset = ^{offset[31:19], offset[1:0]};

  // State register and captured request; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      half_q  <= 1'b0;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state: request capture, per-half wait counting and read-data capture.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (bus.sram_write || bus.sram_read) begin
          state_d = ACCESS;
          op_wr_d = bus.sram_write;
          word_d  = offset[18:2];
          wdata_d = bus.sram_wdata;
          half_d  = 1'b0;
          cnt_d   = '0;
          addr_d  = {offset[18:2], 1'b0};
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (last) begin
          if (!op_wr_q) begin
            if (half_q) rdata_d[31:16] = SRAM_DQ;
            else        rdata_d[15:0]  = SRAM_DQ;
          end
          if (!half_q) begin
            half_d = 1'b1;
            cnt_d  = '0;
            addr_d = {word_q, 1'b1};
          end else begin
            state_d = DONE;
            addr_d  = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // WE_N goes high in the last cycle of each half so it rises before the address moves.
  assign SRAM_ADDR      = addr_q;
  assign SRAM_OE_N      = !((state_q == ACCESS) && !op_wr_q);
  assign SRAM_WE_N      = !((state_q == ACCESS) && op_wr_q && !last);
  assign SRAM_DQ        = ((state_q == ACCESS) && op_wr_q) ?
                          (half_q ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;
  assign SRAM_CE_N      = 1'b0;
  assign SRAM_UB_N      = 1'b0;
  assign SRAM_LB_N      = 1'b0;
  assign bus.sram_rdata = rdata_q;
  assign bus.sram_ready = (state_q == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: one instance with WAIT_CYCLES=1, one with 3,
// each attached to a behavioural 256K x 16 SRAM.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vec = 0;
  int   err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller_if b1();
  sram_controller_if b3();

  logic [17:0] a1, a3;
  wire  [15:0] dq1, dq3;
  logic we1_n, oe1_n, ce1_n, ub1_n, lb1_n;
  logic we3_n, oe3_n, ce3_n, ub3_n, lb3_n;

  pullup (dq1);
  pullup (dq3);

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst_n), .bus(b1), .SRAM_ADDR(a1), .SRAM_DQ(dq1),
    .SRAM_WE_N(we1_n), .SRAM_OE_N(oe1_n), .SRAM_CE_N(ce1_n),
    .SRAM_UB_N(ub1_n), .SRAM_LB_N(lb1_n));

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst_n), .bus(b3), .SRAM_ADDR(a3), .SRAM_DQ(dq3),
    .SRAM_WE_N(we3_n), .SRAM_OE_N(oe3_n), .SRAM_CE_N(ce3_n),
    .SRAM_UB_N(ub3_n), .SRAM_LB_N(lb3_n));

  logic [15:0] mem1 [0:262143];
  logic [15:0] mem3 [0:262143];

  assign dq1 = (!oe1_n && we1_n) ? mem1[a1] : 16'bz;
  assign dq3 = (!oe3_n && we3_n) ? mem3[a3] : 16'bz;
  always @(posedge clk) if (!we1_n) mem1[a1] <= dq1;
  always @(posedge clk) if (!we3_n) mem3[a3] <= dq3;

  int hits45 = 0;
  always @(negedge clk) if (!oe1_n && (a1 == 18'd4 || a1 == 18'd5)) hits45++;

  // Runs one request on the WAIT_CYCLES=1 instance; leaves the request asserted on return.
  task automatic run1(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input int drop_at,
                      output int rdy_cyc, output int rdy_abs, output int oe_cnt,
                      output int we_cnt, output int bad,
                      output logic [17:0] a_c1, output logic [17:0] a_c3);
    logic [17:0] prev_a;
    logic        prev_we_n;
    @(posedge clk); #1;
    b1.sram_read = rd; b1.sram_write = wr; b1.sram_address = a; b1.sram_wdata = wd;
    rdy_cyc = -1; rdy_abs = -1; oe_cnt = 0; we_cnt = 0; bad = 0;
    a_c1 = '0; a_c3 = '0; prev_a = a1; prev_we_n = 1'b1;
    for (int k = 0; k < 40 && rdy_cyc < 0; k++) begin
      if (k == drop_at) begin b1.sram_read = 1'b0; b1.sram_write = 1'b0; end
      @(negedge clk);
      if (a1 !== prev_a && !prev_we_n) bad++;
      if (!we1_n && !oe1_n) bad++;
      if (!oe1_n) oe_cnt++;
      if (!we1_n) we_cnt++;
      if (k == 1) a_c1 = a1;
      if (k == 3) a_c3 = a1;
      if (b1.sram_ready === 1'b1) begin rdy_cyc = k; rdy_abs = cyc; end
      prev_a = a1; prev_we_n = we1_n;
      if (rdy_cyc < 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle1(input int n);
    @(posedge clk); #1;
    b1.sram_read = 1'b0; b1.sram_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    vec++; if (b1.sram_ready !== 1'b0) begin err++; $display("FAIL reset_ready got %b want 0", b1.sram_ready); end
    vec++; if (b1.sram_rdata !== 32'h0) begin err++; $display("FAIL reset_rdata got %h want 0", b1.sram_rdata); end
    vec++; if (a1 !== 18'h0) begin err++; $display("FAIL reset_addr got %h want 0", a1); end
    vec++; if ({we1_n, oe1_n} !== 2'b11) begin err++; $display("FAIL reset_we_oe got %b want 11", {we1_n, oe1_n}); end
    vec++; if ({ce1_n, ub1_n, lb1_n} !== 3'b000) begin err++; $display("FAIL reset_ce_ub_lb got %b want 000", {ce1_n, ub1_n, lb1_n}); end
    vec++; if (dq1 !== 16'hFFFF) begin err++; $display("FAIL reset_dq_released got %h want FFFF (pulled)", dq1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_read;
    int rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    run1(1'b1, 1'b0, 32'd1024, 32'h0, -1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (rc != 5) begin err++; $display("FAIL read_latency got %0d want 5", rc); end
    vec++; if (oc != 4) begin err++; $display("FAIL read_oe_cycles got %0d want 4", oc); end
    vec++; if (x1 !== 18'd0 || x3 !== 18'd1) begin err++; $display("FAIL read_addr_seq got %0d,%0d want 0,1", x1, x3); end
    vec++; if (b1.sram_rdata !== 32'hBEEFDEAD) begin err++; $display("FAIL read_data got %h want BEEFDEAD", b1.sram_rdata); end
    idle1(3);
    @(negedge clk);
    vec++; if (b1.sram_ready !== 1'b0 || b1.sram_rdata !== 32'hBEEFDEAD) begin
      err++; $display("FAIL read_hold got ready=%b rdata=%h want 0/BEEFDEAD", b1.sram_ready, b1.sram_rdata); end
  endtask

  task automatic test_write;
    int rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    run1(1'b0, 1'b1, 32'd1028, 32'h12345678, -1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (rc != 5) begin err++; $display("FAIL write_latency got %0d want 5", rc); end
    vec++; if (wc != 2 || bd != 0 || oc != 0) begin
      err++; $display("FAIL write_strobes got we=%0d bad=%0d oe=%0d want 2/0/0", wc, bd, oc); end
    idle1(1);
    @(negedge clk);
    vec++; if (mem1[2] !== 16'h5678 || mem1[3] !== 16'h1234) begin
      err++; $display("FAIL write_mem got %h,%h want 5678,1234", mem1[2], mem1[3]); end
    vec++; if (dq1 !== 16'hFFFF) begin err++; $display("FAIL write_dq_release got %h want FFFF (pulled)", dq1); end
  endtask

  task automatic test_back_to_back;
    int rc1, ra1, rc2, ra2, oc1, oc2, wc, bd, h0, extra; logic [17:0] x1, x3;
    h0 = hits45;
    run1(1'b1, 1'b0, 32'd1032, 32'h0, -1, rc1, ra1, oc1, wc, bd, x1, x3);
    vec++; if (b1.sram_rdata !== 32'h22221111) begin err++; $display("FAIL b2b_first_data got %h want 22221111", b1.sram_rdata); end
    run1(1'b1, 1'b0, 32'd1036, 32'h0, -1, rc2, ra2, oc2, wc, bd, x1, x3);
    vec++; if (ra2 - ra1 != 6 || rc1 != 5) begin err++; $display("FAIL b2b_spacing got %0d (first %0d) want 6 (5)", ra2 - ra1, rc1); end
    vec++; if (b1.sram_rdata !== 32'h44443333) begin err++; $display("FAIL b2b_second_data got %h want 44443333", b1.sram_rdata); end
    extra = 0;
    @(posedge clk); #1;
    b1.sram_read = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b1.sram_ready === 1'b1) extra++;
    end
    vec++; if (extra != 0 || hits45 - h0 != 4) begin
      err++; $display("FAIL b2b_no_repeat got extra_ready=%0d reads_4_5=%0d want 0/4", extra, hits45 - h0); end
  endtask

  task automatic test_both_high;
    int rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    run1(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, -1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (rc != 5 || oc != 0 || wc != 2) begin
      err++; $display("FAIL both_strobes got rdy=%0d oe=%0d we=%0d want 5/0/2", rc, oc, wc); end
    idle1(1);
    vec++; if (mem1[8] !== 16'hF00D || mem1[9] !== 16'hCAFE) begin
      err++; $display("FAIL both_mem got %h,%h want F00D,CAFE", mem1[8], mem1[9]); end
  endtask

  task automatic test_wrap;
    int rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    run1(1'b1, 1'b0, 32'h0000_0003, 32'h0, -1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (x1 !== 18'h3FE00 || x3 !== 18'h3FE01) begin
      err++; $display("FAIL wrap_addr got %h,%h want 3FE00,3FE01", x1, x3); end
    vec++; if (b1.sram_rdata !== 32'h5A5AA5A5) begin err++; $display("FAIL wrap_data got %h want 5A5AA5A5", b1.sram_rdata); end
    idle1(1);
  endtask

  task automatic test_drop;
    int rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    run1(1'b1, 1'b0, 32'd1024, 32'h0, 1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (rc != 5 || b1.sram_rdata !== 32'hBEEFDEAD) begin
      err++; $display("FAIL drop_complete got rdy=%0d rdata=%h want 5/BEEFDEAD", rc, b1.sram_rdata); end
    idle1(1);
  endtask

  task automatic test_reset_mid_write;
    int rdy, rc, ra, oc, wc, bd; logic [17:0] x1, x3;
    @(posedge clk); #1;
    b1.sram_write = 1'b1; b1.sram_address = 32'd1044; b1.sram_wdata = 32'h0BAD0BAD;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vec++; if (we1_n !== 1'b1 || oe1_n !== 1'b1 || dq1 !== 16'hFFFF || a1 !== 18'd0 || b1.sram_ready !== 1'b0) begin
      err++; $display("FAIL rst_abort got we=%b oe=%b dq=%h addr=%h rdy=%b want 1/1/FFFF/0/0",
                      we1_n, oe1_n, dq1, a1, b1.sram_ready); end
    b1.sram_write = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    rdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (b1.sram_ready === 1'b1) rdy++;
    end
    vec++; if (rdy != 0) begin err++; $display("FAIL rst_no_ready got %0d pulses want 0", rdy); end
    run1(1'b1, 1'b0, 32'd1024, 32'h0, -1, rc, ra, oc, wc, bd, x1, x3);
    vec++; if (rc != 5 || b1.sram_rdata !== 32'hBEEFDEAD) begin
      err++; $display("FAIL rst_recover got rdy=%0d rdata=%h want 5/BEEFDEAD", rc, b1.sram_rdata); end
    idle1(1);
  endtask

  task automatic test_wait3;
    int rc, h20, h21;
    @(posedge clk); #1;
    b3.sram_read = 1'b1; b3.sram_address = 32'd1064;
    rc = -1; h20 = 0; h21 = 0;
    for (int k = 0; k < 40 && rc < 0; k++) begin
      @(negedge clk);
      if (!oe3_n && a3 == 18'd20) h20++;
      if (!oe3_n && a3 == 18'd21) h21++;
      if (b3.sram_ready === 1'b1) rc = k;
      if (rc < 0) begin @(posedge clk); #1; end
    end
    vec++; if (rc != 9) begin err++; $display("FAIL w3_latency got %0d want 9", rc); end
    vec++; if (h20 != 4 || h21 != 4) begin err++; $display("FAIL w3_half_len got %0d,%0d want 4,4", h20, h21); end
    vec++; if (b3.sram_rdata !== 32'h99997777) begin err++; $display("FAIL w3_data got %h want 99997777", b3.sram_rdata); end
    @(posedge clk); #1 b3.sram_read = 1'b0;
  endtask

  initial begin
    b1.sram_read = 1'b0; b1.sram_write = 1'b0; b1.sram_address = '0; b1.sram_wdata = '0;
    b3.sram_read = 1'b0; b3.sram_write = 1'b0; b3.sram_address = '0; b3.sram_wdata = '0;
    mem1[0] = 16'hDEAD; mem1[1] = 16'hBEEF;
    mem1[4] = 16'h1111; mem1[5] = 16'h2222; mem1[6] = 16'h3333; mem1[7] = 16'h4444;
    mem1[18'h3FE00] = 16'hA5A5; mem1[18'h3FE01] = 16'h5A5A;
    mem3[20] = 16'h7777; mem3[21] = 16'h9999;
    test_reset;
    test_read;
    test_write;
    test_back_to_back;
    test_both_high;
    test_wrap;
    test_drop;
    test_reset_mid_write;
    test_wait3;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
